mul_arbiter: RTL and testbench



---
 rtl/mul_arbiter.sv | 124 ++++++++++++
 tb/tb_mul_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among NUM_REQ requesters.
// One transaction in flight: accept in IDLE, pulse load, wait for done, hold response until taken.
module mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [2*WIDTH-1:0]         resp_product,
  output logic                       mul_load,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_product
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [IDXW-1:0]    grant_idx;
  logic               any_valid;

  // Both passes scan downward so the lowest index wins; the second pass
  // (indices at or above ptr) overrides the wrapped-around first pass.
  always_comb begin
    any_valid = |req_valid;
    grant_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_valid[NUM_REQ-1-j]) begin
        grant_idx = IDXW'(NUM_REQ-1-j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_valid[NUM_REQ-1-j] && ((NUM_REQ-1-j) >= 32'(ptr_q))) begin
        grant_idx = IDXW'(NUM_REQ-1-j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    a_d        = a_q;
    b_d        = b_q;
    product_d  = product_q;
    req_ready  = '0;
    resp_valid = '0;
    mul_load   = 1'b0;

    case (state_q)
      IDLE: begin
        // No accept strobe during reset: the latch would be discarded.
        if (any_valid && !reset) begin
          req_ready[grant_idx] = 1'b1;
          grant_d = grant_idx;
          a_d     = req_a[grant_idx*WIDTH +: WIDTH];
          b_d     = req_b[grant_idx*WIDTH +: WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          product_d = mul_product;
          state_d   = RESP;
        end
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) begin
          ptr_d   = (grant_q == IDXW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
    end
  end

  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign resp_product = product_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier of adjustable latency.
module tb_mul_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [63:0]  resp_product;
  logic         mul_load;
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic         mul_done;
  logic [63:0]  mul_product;

  logic         model_done;
  logic [63:0]  model_prod;
  int unsigned  cnt;
  int unsigned  lat;
  logic         inj_done;
  logic [63:0]  inj_prod;

  int errors = 0;
  int checks = 0;

  int unsigned rr_g[5] = '{0, 1, 2, 3, 0};
  logic [63:0] rr_p[5] = '{64'd1, 64'd6, 64'd20, 64'd42, 64'd1};

  mul_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .mul_load     (mul_load),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      cnt        <= 0;
      model_done <= 1'b0;
      model_prod <= '0;
    end else begin
      model_done <= 1'b0;
      if (mul_load) begin
        cnt        <= lat;
        model_prod <= {32'h0, mul_a} * {32'h0, mul_b};
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) model_done <= 1'b1;
      end
    end
  end

  assign mul_done    = model_done | inj_done;
  assign mul_product = inj_done ? inj_prod : model_prod;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the response, then checks it and that mul_done preceded it by one cycle.
  task automatic wait_resp(input string tag, input logic [3:0] exp_v, input logic [63:0] exp_p);
    logic prev_done;
    prev_done = 1'b0;
    for (int n = 0; n < 60 && resp_valid == 4'b0; n++) begin
      prev_done = mul_done;
      tick();
    end
    chk({tag, "_valid"}, resp_valid, exp_v);
    chk({tag, "_prod"}, resp_product, exp_p);
    chk({tag, "_lat"}, prev_done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    inj_done = 1'b0; inj_prod = '0; lat = 10;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_product", resp_product, 0);
    chk("rst_mul_load", mul_load, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);

    // Single request from requester 2
    req_a[2*32 +: 32] = 32'd7; req_b[2*32 +: 32] = 32'd6; req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    chk("single_noload", mul_load, 0);
    tick();
    req_valid = '0;
    #1;
    chk("single_ready_off", req_ready, 0);
    chk("single_load", mul_load, 1);
    chk("single_mul_a", mul_a, 7);
    chk("single_mul_b", mul_b, 6);
    tick();
    chk("single_load_off", mul_load, 0);
    wait_resp("single", 4'b0100, 64'd42);
    resp_ready = 4'b0100;
    #1;
    tick();
    resp_ready = '0;
    chk("single_idle", resp_valid, 0);

    // Round robin with all four requesters valid, from ptr 0
    reset = 1'b1; tick(); reset = 1'b0; lat = 2;
    req_a[0 +: 32] = 32'd1; req_b[0 +: 32] = 32'd1;
    req_a[32 +: 32] = 32'd2; req_b[32 +: 32] = 32'd3;
    req_a[64 +: 32] = 32'd4; req_b[64 +: 32] = 32'd5;
    req_a[96 +: 32] = 32'd6; req_b[96 +: 32] = 32'd7;
    req_valid = 4'hF; resp_ready = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", req_ready, 64'd1 << rr_g[k]);
      tick();
      wait_resp("rr", 4'(64'd1 << rr_g[k]), rr_p[k]);
      tick();
    end
    req_valid = '0;

    // Pointer wrap: last grant 3, then requesters 1 and 3
    req_valid = 4'b1000;
    #1;
    chk("wrap_pre_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_resp("wrap_pre", 4'b1000, 64'd42);
    tick();
    req_valid = 4'b1010;
    #1;
    chk("wrap_first_grant", req_ready, 4'b0010);
    tick();
    wait_resp("wrap_first", 4'b0010, 64'd6);
    tick();
    chk("wrap_second_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_resp("wrap_second", 4'b1000, 64'd42);
    tick();

    // Response back-pressure, with a spurious mul_done during the stall
    resp_ready = '0;
    req_a[0 +: 32] = 32'd3; req_b[0 +: 32] = 32'd5;
    req_valid = 4'b0011;
    #1;
    chk("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    wait_resp("bp", 4'b0001, 64'd15);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", resp_valid, 4'b0001);
      chk("bp_prod_hold", resp_product, 64'd15);
      chk("bp_no_ready", req_ready, 0);
      inj_prod = 64'hDEAD_BEEF;
      inj_done = (i == 1);
      tick();
    end
    inj_done = 1'b0;
    resp_ready = 4'b0001;
    #1;
    tick();
    resp_ready = '0;
    chk("bp_reidle_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_resp("bp_next", 4'b0010, 64'd6);
    resp_ready = 4'b0010;
    #1;
    tick();

    // Width boundary
    resp_ready = 4'hF;
    req_a[64 +: 32] = 32'hFFFF_FFFF; req_b[64 +: 32] = 32'hFFFF_FFFF;
    req_valid = 4'b0100;
    #1;
    chk("wide_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_resp("wide", 4'b0100, 64'hFFFF_FFFE_0000_0001);
    tick();

    // Reset while waiting for the multiplier, then a spurious done in IDLE
    lat = 20;
    req_a[96 +: 32] = 32'd9; req_b[96 +: 32] = 32'd9;
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("rw_wait_noresp", resp_valid, 0);
    chk("rw_wait_mul_a", mul_a, 9);
    reset = 1'b1;
    tick();
    chk("rw_req_ready", req_ready, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_resp_product", resp_product, 0);
    chk("rw_mul_load", mul_load, 0);
    chk("rw_mul_a", mul_a, 0);
    chk("rw_mul_b", mul_b, 0);
    reset = 1'b0;
    tick();
    inj_prod = 64'h51; inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rw_spur_noresp", resp_valid, 0);
      chk("rw_spur_prod", resp_product, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
